// File: rtl/stream_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stream_mux_pkg
//  Purpose  : Shared types and helpers for the N:1 stream multiplexer.
//             - rr_mode_e : channel selection mode (explicit sel / round-robin)
//             - ch_w()    : channel-index width, never less than 1 bit
//  Revision : 1.0  initial release
// ============================================================================
package stream_mux_pkg;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } rr_mode_e;

    // A single channel still needs a 1-bit index port, so clamp at 1.
    function automatic int ch_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : stream_mux_pkg
`default_nettype wire

// File: rtl/mux_n_1_slice.sv
`default_nettype none
// ============================================================================
//  Module   : mux_n_1_slice
//  Purpose  : Combinational N:1 select of one SLICE_W-bit slice.
//  Ports    : i_data  [N_CH*SLICE_W] slice k of each channel at [k*SLICE_W +: SLICE_W]
//             i_sel   [CH_W]         channel index to pass through
//             o_data  [SLICE_W]      selected slice, zero when i_sel >= N_CH
//  Revision : 1.0  initial release
// ============================================================================
module mux_n_1_slice
    import stream_mux_pkg::*;
#(
    parameter  int N_CH    = 4,
    parameter  int SLICE_W = 2,
    localparam int CH_W    = ch_w(N_CH)
) (
    input  logic [N_CH*SLICE_W-1:0] i_data,
    input  logic [CH_W-1:0]         i_sel,
    output logic [SLICE_W-1:0]      o_data
);

    always_comb begin
        o_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (i_sel == CH_W'(k)) begin
                o_data = i_data[k*SLICE_W +: SLICE_W];
            end
        end
    end

endmodule : mux_n_1_slice
`default_nettype wire

// File: rtl/stream_mux_n_1.sv
`default_nettype none
// ============================================================================
//  Module   : stream_mux_n_1
//  Purpose  : Registered N-channel stream multiplexer with valid/ready on
//             every port. Channel chosen by sel (RR_MODE=0) or round-robin
//             over valid channels (RR_MODE=1). One-cycle latency, full
//             throughput, back-pressure through the output register.
//  Ports    : clk, rst               clock, synchronous active-high reset
//             sel       [CH_W]        requested channel (RR_MODE=0 only)
//             in_valid  [N_CH]        per-channel valid
//             in_data   [N_CH*DATA_W] channel k at [k*DATA_W +: DATA_W]
//             in_ready  [N_CH]        per-channel ready, one-hot or zero
//             out_valid/out_data/out_ch  registered output beat and source
//             out_ready               consumer ready
//  Revision : 1.0  initial release
// ============================================================================
module stream_mux_n_1
    import stream_mux_pkg::*;
#(
    parameter  int N_CH    = 4,
    parameter  int DATA_W  = 8,
    parameter  int SLICE_W = 2,
    parameter  int RR_MODE = 0,
    localparam int CH_W    = ch_w(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CH_W-1:0]          sel,
    input  logic [N_CH-1:0]          in_valid,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    output logic [N_CH-1:0]          in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch,
    input  logic                     out_ready
);

    localparam rr_mode_e c_MODE    = (RR_MODE != 0) ? MODE_RR : MODE_SEL;
    localparam int       c_N_SLICE = DATA_W / SLICE_W;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [CH_W-1:0]   r_out_ch;
    logic [CH_W-1:0]   r_last;

    logic              w_pipe_ready;
    logic              w_sel_vld;
    logic              w_rr_vld;
    logic [CH_W-1:0]   w_rr_g;
    logic              w_gnt_vld;
    logic [CH_W-1:0]   w_gnt;
    logic [N_CH-1:0]   w_in_ready;
    logic              w_xfer;
    logic [DATA_W-1:0] w_mux_data;
    int                w_best_d;
    int                w_dist;

    assign w_pipe_ready = !r_out_valid || out_ready;

    // Explicit selection: out-of-range sel simply grants nothing.
    assign w_sel_vld = (int'(sel) < N_CH);

    // Round-robin: among valid channels pick the one closest after r_last,
    // where distance 0 is r_last+1 and distance N_CH-1 is r_last itself.
    always_comb begin
        w_rr_vld = 1'b0;
        w_rr_g   = '0;
        w_best_d = N_CH;
        w_dist   = 0;
        for (int k = 0; k < N_CH; k++) begin
            w_dist = (k + N_CH - 1 - int'(r_last)) % N_CH;
            if (in_valid[k] && (w_dist < w_best_d)) begin
                w_best_d = w_dist;
                w_rr_g   = CH_W'(k);
                w_rr_vld = 1'b1;
            end
        end
    end

    always_comb begin
        if (c_MODE == MODE_RR) begin
            w_gnt_vld = w_rr_vld;
            w_gnt     = w_rr_g;
        end else begin
            w_gnt_vld = w_sel_vld;
            w_gnt     = sel;
        end
    end

    // Ready is offered to the granted channel whether or not it is valid,
    // and withheld while reset is asserted.
    always_comb begin
        w_in_ready = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_in_ready[k] = !rst && w_gnt_vld && w_pipe_ready && (w_gnt == CH_W'(k));
        end
    end

    assign w_xfer = |(w_in_ready & in_valid);

    // Datapath: DATA_W/SLICE_W narrow muxes, each fed the matching slice of
    // every channel.
    for (genvar s = 0; s < c_N_SLICE; s++) begin : g_slice
        logic [N_CH*SLICE_W-1:0] w_slice_in;

        for (genvar k = 0; k < N_CH; k++) begin : g_ch
            assign w_slice_in[k*SLICE_W +: SLICE_W] = in_data[k*DATA_W + s*SLICE_W +: SLICE_W];
        end

        mux_n_1_slice #(
            .N_CH    (N_CH),
            .SLICE_W (SLICE_W)
        ) u_slice (
            .i_data (w_slice_in),
            .i_sel  (w_gnt),
            .o_data (w_mux_data[s*SLICE_W +: SLICE_W])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_last      <= CH_W'(N_CH - 1);
        end else if (w_xfer) begin
            // Covers simultaneous drain + accept: overwrite, stay valid.
            r_out_valid <= 1'b1;
            r_out_data  <= w_mux_data;
            r_out_ch    <= w_gnt;
            r_last      <= w_gnt;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;

endmodule : stream_mux_n_1
`default_nettype wire

// File: tb/tb_stream_mux_n_1.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_mux_n_1
//  Purpose  : Self-checking bench for stream_mux_n_1. Three instances share
//             one set of stimulus: N=4 sel mode, N=4 round-robin, N=3 sel
//             mode. A behavioural model predicts grants and output beats.
//  Revision : 1.0  initial release
// ============================================================================
module tb_stream_mux_n_1;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  sel;
    logic [3:0]  in_valid;
    logic [7:0]  ch_data [4];
    logic [31:0] in_data;
    logic        out_ready;

    assign in_data = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};

    logic [3:0] ir0, ir1;
    logic [2:0] ir2;
    logic       ov0, ov1, ov2;
    logic [7:0] od0, od1, od2;
    logic [1:0] och0, och1, och2;

    stream_mux_n_1 #(.N_CH(4), .DATA_W(8), .SLICE_W(2), .RR_MODE(0)) u_dut_sel (
        .clk(clk), .rst(rst), .sel(sel), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ir0), .out_valid(ov0), .out_data(od0), .out_ch(och0), .out_ready(out_ready)
    );

    stream_mux_n_1 #(.N_CH(4), .DATA_W(8), .SLICE_W(2), .RR_MODE(1)) u_dut_rr (
        .clk(clk), .rst(rst), .sel(sel), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ir1), .out_valid(ov1), .out_data(od1), .out_ch(och1), .out_ready(out_ready)
    );

    stream_mux_n_1 #(.N_CH(3), .DATA_W(8), .SLICE_W(2), .RR_MODE(0)) u_dut_n3 (
        .clk(clk), .rst(rst), .sel(sel), .in_valid(in_valid[2:0]), .in_data(in_data[23:0]),
        .in_ready(ir2), .out_valid(ov2), .out_data(od2), .out_ch(och2), .out_ready(out_ready)
    );

    // ------------------------------------------------------------------
    // Reference model: per-instance holding register and RR pointer
    // ------------------------------------------------------------------
    int         c_n  [3] = '{4, 4, 3};
    bit         c_rr [3] = '{1'b0, 1'b1, 1'b0};
    bit         m_ov   [3];
    logic [7:0] m_data [3];
    int         m_ch   [3];
    int         m_last [3];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Which channel the instance should grant given current inputs/state.
    function automatic void predict(input int d, output bit found, output int g);
        int n;
        n     = c_n[d];
        found = 1'b0;
        g     = 0;
        if (!c_rr[d]) begin
            if (int'(sel) < n) begin
                found = 1'b1;
                g     = int'(sel);
            end
        end else begin
            for (int i = 1; i <= n; i++) begin
                int k;
                k = (m_last[d] + i) % n;
                if (!found && in_valid[2'(k)]) begin
                    found = 1'b1;
                    g     = k;
                end
            end
        end
    endfunction

    task automatic model_reset_state();
        for (int d = 0; d < 3; d++) begin
            m_ov[d]   = 1'b0;
            m_data[d] = 8'h00;
            m_ch[d]   = 0;
            m_last[d] = c_n[d] - 1;
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 3; d++) begin
            bit         found;
            int         g;
            logic [3:0] exp_ir;
            logic [3:0] obs_ir;
            logic       obs_ov;
            logic [7:0] obs_od;
            logic [1:0] obs_ch;
            predict(d, found, g);
            exp_ir = 4'h0;
            if (!rst && found && (!m_ov[d] || out_ready)) exp_ir = 4'(1 << g);
            case (d)
                0:       begin obs_ir = ir0;          obs_ov = ov0; obs_od = od0; obs_ch = och0; end
                1:       begin obs_ir = ir1;          obs_ov = ov1; obs_od = od1; obs_ch = och1; end
                default: begin obs_ir = {1'b0, ir2};  obs_ov = ov2; obs_od = od2; obs_ch = och2; end
            endcase
            chk($sformatf("d%0d_in_ready", d),  32'(obs_ir), 32'(exp_ir));
            chk($sformatf("d%0d_out_valid", d), 32'(obs_ov), 32'(m_ov[d]));
            chk($sformatf("d%0d_out_data", d),  32'(obs_od), 32'(m_data[d]));
            chk($sformatf("d%0d_out_ch", d),    32'(obs_ch), 32'(m_ch[d]));
        end
    endtask

    // Apply the clock edge to the model using the inputs present at the edge.
    task automatic model_edge();
        for (int d = 0; d < 3; d++) begin
            bit found;
            int g;
            predict(d, found, g);
            if (rst) begin
                m_ov[d]   = 1'b0;
                m_data[d] = 8'h00;
                m_ch[d]   = 0;
                m_last[d] = c_n[d] - 1;
            end else if (found && (!m_ov[d] || out_ready) && in_valid[2'(g)]) begin
                m_ov[d]   = 1'b1;
                m_data[d] = ch_data[2'(g)];
                m_ch[d]   = g;
                m_last[d] = g;
            end else if (m_ov[d] && out_ready) begin
                m_ov[d] = 1'b0;
            end
        end
    endtask

    // Inputs are already set (1 ns after an edge): check mid-cycle, clock.
    task automatic cycle();
        #2;
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    int rr_a [5] = '{0, 1, 2, 3, 0};
    int rr_b [4] = '{2, 3, 0, 2};

    initial begin
        rst       = 1'b1;
        sel       = 2'd0;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) ch_data[i] = 8'h10 + 8'(i);
        model_reset_state();
        @(posedge clk);
        model_edge();
        #1;

        // Reset held with every channel valid
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("rst_out_valid", 32'(ov1), 32'd0);
            chk("rst_in_ready_rr", 32'(ir1), 32'd0);
        end

        // Explicit select of channel 2
        rst        = 1'b0;
        sel        = 2'd2;
        in_valid   = 4'b0100;
        ch_data[2] = 8'hC3;
        #1;
        chk("sel2_in_ready", 32'(ir0), 32'b0100);
        cycle();
        chk("sel2_out_valid", 32'(ov0), 32'd1);
        chk("sel2_out_data", 32'(od0), 32'hC3);
        chk("sel2_out_ch", 32'(och0), 32'd2);

        // Stall three cycles while sel and data wander
        out_ready = 1'b0;
        in_valid  = 4'hF;
        for (int i = 0; i < 3; i++) begin
            sel = 2'(i);
            for (int c = 0; c < 4; c++) ch_data[c] = 8'($urandom);
            #1;
            chk("stall_in_ready", 32'(ir0), 32'd0);
            cycle();
            chk("stall_out_data", 32'(od0), 32'hC3);
            chk("stall_out_ch", 32'(och0), 32'd2);
        end

        // Release: drain and accept in the same cycle
        out_ready  = 1'b1;
        sel        = 2'd1;
        ch_data[1] = 8'h5A;
        #1;
        chk("release_in_ready", 32'(ir0), 32'b0010);
        cycle();
        chk("release_out_data", 32'(od0), 32'h5A);
        chk("release_out_valid", 32'(ov0), 32'd1);

        // Back-to-back stream on channel 1
        in_valid = 4'b0010;
        for (int i = 1; i <= 8; i++) begin
            ch_data[1] = 8'(i);
            cycle();
            chk("b2b_out_valid", 32'(ov0), 32'd1);
            chk("b2b_out_data", 32'(od0), 32'(i));
        end

        // Round-robin order, with the 3-channel instance given sel=3
        rst = 1'b1;
        cycle();
        rst      = 1'b0;
        sel      = 2'd3;
        in_valid = 4'hF;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("rr_all_out_ch", 32'(och1), 32'(rr_a[i]));
            chk("n3_sel3_out_valid", 32'(ov2), 32'd0);
        end
        in_valid = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("rr_skip1_out_ch", 32'(och1), 32'(rr_b[i]));
        end

        // Randomised traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 63) == 0);
            sel       = 2'($urandom);
            in_valid  = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < 4; c++) ch_data[c] = 8'($urandom);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_stream_mux_n_1
`default_nettype wire
